// File: rtl/restoring_divider_4_pkg.sv
// Shared ALU definitions: datapath width and divider state encoding.
package restoring_divider_4_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : restoring_divider_4_pkg

// File: rtl/restoring_divider_4_div_sub_step.sv
// Combinational trial subtract for one restoring-division step.
// The subtraction is done as shifted + ~D + 1, the same invert-and-carry
// form the ALU adder uses, widened by one bit so the MSB acts as borrow.
module div_sub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH+1:0] diff,
  output logic             borrow
);

  logic [WIDTH+1:0] shiftedExt;
  logic [WIDTH+1:0] dInv;

  // Zero-extend the partial remainder, invert the zero-extended divisor, add with carry-in.
  always_comb begin
    shiftedExt = {1'b0, shifted};
    dInv       = ~{2'b00, d};
    diff       = shiftedExt + dInv + {{(WIDTH+1){1'b0}}, 1'b1};
    borrow     = diff[WIDTH+1];
  end

endmodule : div_sub_step

// File: rtl/restoring_divider_4.sv
// Sequential unsigned restoring divider: one shift/trial-subtract per clock,
// start/busy/done handshake, quotient/remainder/div_by_zero held between runs.
module restoring_divider_4
  import restoring_divider_4_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] qs_q;
  logic [WIDTH-1:0] qs_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   r_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .shifted (shifted),
    .d       (d_q),
    .diff    (diff),
    .borrow  (borrow)
  );

  // One division step: shift next dividend bit in, keep the difference or restore on borrow.
  always_comb begin
    shifted = {r_q[WIDTH-1:0], qs_q[WIDTH-1]};
    r_d     = borrow ? shifted : diff[WIDTH:0];
    qs_d    = {qs_q[WIDTH-2:0], ~borrow};
  end

  // Control FSM plus datapath and output registers; results load on the edge entering DONE
  // so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      qs_q        <= '0;
      d_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              qs_q    <= dividend;
              d_q     <= divisor;
              r_q     <= '0;
              cnt_q   <= CW'(WIDTH - 1);
            end
          end
        end
        ST_CALC: begin
          r_q  <= r_d;
          qs_q <= qs_d;
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            quotient_q  <= qs_d;
            remainder_q <= r_d[WIDTH-1:0];
            dbz_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : restoring_divider_4

// File: tb/tb_restoring_divider_4.sv
// Directed self-checking bench for restoring_divider_4.
module tb_restoring_divider_4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;
  int doneCount;

  restoring_divider_4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse, sampled away from the active edge
  always @(negedge clk) if (done === 1'b1) doneCount++;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, wait (bounded) for done, check latency and results
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] expQ, input logic [3:0] expR,
                               input logic expZ, input int expLat, input string tag);
    int lat;
    int busyCycles;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = 4'hx;
    divisor  = 4'hx;
    lat        = 1;
    busyCycles = 0;
    if (busy) busyCycles++;
    checkOutput({tag, "_busy1"}, busy, 1);
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (busy) busyCycles++;
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_busyCycles"}, busyCycles, expLat);
    checkOutput({tag, "_q"}, quotient, expQ);
    checkOutput({tag, "_r"}, remainder, expR);
    checkOutput({tag, "_dbz"}, div_by_zero, expZ);
    tick();
    checkOutput({tag, "_idleBusy"}, busy, 0);
    checkOutput({tag, "_idleDone"}, done, 0);
    checkOutput({tag, "_holdQ"}, quotient, expQ);
  endtask

  initial begin
    int dc0;
    logic [3:0] mq;
    logic [3:0] mr;
    logic       mz;
    checks    = 0;
    errors    = 0;
    doneCount = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_q", quotient, 0);
    checkOutput("rst_r", remainder, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    applyStimulus(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "d13_3");
    applyStimulus(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1, "d7_0");
    applyStimulus(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, "d15_1");
    applyStimulus(4'd2, 4'd5, 4'd0, 4'd2, 1'b0, 5, "d2_5");
    applyStimulus(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, "d15_15");
    applyStimulus(4'd0, 4'd9, 4'd0, 4'd0, 1'b0, 5, "d0_9");

    // start held through CALC and DONE with new operands must be ignored
    dc0      = doneCount;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    tick();
    dividend = 4'd9;
    divisor  = 4'd2;
    for (int i = 0; i < 4 && done !== 1'b1; i++) tick();
    checkOutput("hold_done", done, 1);
    checkOutput("hold_q", quotient, 4);
    checkOutput("hold_r", remainder, 1);
    tick();
    start = 1'b0;
    checkOutput("hold_idleBusy", busy, 0);
    tick();
    checkOutput("hold_stillIdle", busy, 0);
    checkOutput("hold_doneCount", doneCount - dc0, 1);
    applyStimulus(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, "d9_2");

    // reset during the second CALC cycle aborts silently
    dc0      = doneCount;
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    tick();
    start = 1'b0;
    tick();
    checkOutput("abort_busyCalc", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_q", quotient, 0);
    checkOutput("abort_r", remainder, 0);
    checkOutput("abort_dbz", div_by_zero, 0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("abort_noDone", doneCount - dc0, 0);
    applyStimulus(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 5, "d14_4");

    // Full operand sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 4'hF;
          mr = 4'(a);
          mz = 1'b1;
        end else begin
          mq = 4'(a / b);
          mr = 4'(a % b);
          mz = 1'b0;
        end
        applyStimulus(4'(a), 4'(b), mq, mr, mz, (b == 0) ? 1 : 5, $sformatf("sw%0d_%0d", a, b));
        if (b != 0) begin
          checkOutput($sformatf("sw%0d_%0d_recon", a, b), 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
          checkOutput($sformatf("sw%0d_%0d_rlt", a, b), 32'(remainder < 4'(b)), 1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule : tb_restoring_divider_4
